// File: rtl/uart_pkg.sv
// Shared constants and types for the KnightsTour UART command front end.
package uart_pkg;

  localparam int BAUD_DIV_DEF     = 2604;
  localparam int BYTE_TIMEOUT_DEF = 2**20;

  localparam logic [7:0] POS_ACK  = 8'hA5;
  localparam logic [7:0] MOVE_ACK = 8'h5A;

  typedef enum logic {HIGH = 1'b0, LOW = 1'b1} asm_state_t;

endpackage

// File: rtl/uart_trx.sv
// 8N1 UART transceiver: mid-bit sampling receiver and shift-register transmitter,
// running independently of each other.
module uart_trx import uart_pkg::*; #(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  input  logic       clr_rx_rdy,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done
);

  localparam int BW = $clog2(BAUD_DIV) + 1;

  logic          rx_ff1, rx_sync, rx_prev, rx_fall;
  logic          rx_busy;
  logic [BW-1:0] rx_baud, rx_target;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift;

  logic [9:0]    tx_shift;
  logic          tx_busy;
  logic [BW-1:0] tx_baud;
  logic [3:0]    tx_bit;

  // Flops preset to the idle level so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1  <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_ff1  <= RX;
      rx_sync <= rx_ff1;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall   = rx_prev & ~rx_sync;
  assign rx_target = (rx_bit == 4'd0) ? BW'(BAUD_DIV/2 - 1) : BW'(BAUD_DIV - 1);
  assign rx_data   = rx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_busy  <= 1'b0;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_rdy   <= 1'b0;
    end else begin
      if (clr_rx_rdy)
        rx_rdy <= 1'b0;
      if (!rx_busy) begin
        if (rx_fall) begin
          rx_busy <= 1'b1;
          rx_baud <= '0;
          rx_bit  <= '0;
        end
      end else if (rx_baud == rx_target) begin
        rx_baud <= '0;
        rx_bit  <= rx_bit + 4'd1;
        if (rx_bit >= 4'd1 && rx_bit <= 4'd8)
          rx_shift <= {rx_sync, rx_shift[7:1]};
        // Stop-bit sample: its value is ignored, the frame is simply complete.
        if (rx_bit == 4'd9) begin
          rx_busy <= 1'b0;
          rx_rdy  <= 1'b1;
        end
      end else begin
        rx_baud <= rx_baud + BW'(1);
      end
    end
  end

  // Shifting in ones leaves the line idling high once the stop bit has gone out.
  assign TX = tx_shift[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '1;
      tx_busy  <= 1'b0;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_done  <= 1'b0;
    end else if (!tx_busy) begin
      if (trmt) begin
        tx_shift <= {1'b1, tx_data, 1'b0};
        tx_busy  <= 1'b1;
        tx_done  <= 1'b0;
        tx_baud  <= '0;
        tx_bit   <= '0;
      end
    end else if (tx_baud == BW'(BAUD_DIV - 1)) begin
      tx_baud  <= '0;
      tx_shift <= {1'b1, tx_shift[9:1]};
      tx_bit   <= tx_bit + 4'd1;
      if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
        tx_done <= 1'b1;
      end
    end else begin
      tx_baud <= tx_baud + BW'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Command front end: pairs received bytes (high first) into 16-bit commands and
// forwards single-byte responses to the transmitter.
module uart_cmd_wrapper import uart_pkg::*; #(
  parameter int BAUD_DIV     = BAUD_DIV_DEF,
  parameter int BYTE_TIMEOUT = BYTE_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        trmt,
  input  logic [7:0]  resp,
  output logic        tx_done
);

  localparam int TW = $clog2(BYTE_TIMEOUT) + 1;

  logic          rx_rdy;
  logic [7:0]    rx_data;
  asm_state_t    state, next_state;
  logic          load_high, set_cmd, discard, timed_out;
  logic [TW-1:0] to_cnt;
  logic [7:0]    high_byte;

  // Acknowledging rx_rdy on the following cycle turns it into a one-cycle pulse.
  uart_trx #(.BAUD_DIV(BAUD_DIV)) u_trx (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .TX         (TX),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (rx_rdy),
    .trmt       (trmt),
    .tx_data    (resp),
    .tx_done    (tx_done)
  );

  assign timed_out = (to_cnt == TW'(BYTE_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HIGH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      HIGH: if (rx_rdy) next_state = LOW;
      LOW:  if (rx_rdy || timed_out) next_state = HIGH;
      default: next_state = HIGH;
    endcase
  end

  always_comb begin
    load_high = (state == HIGH) && rx_rdy;
    set_cmd   = (state == LOW) && rx_rdy;
    discard   = (state == LOW) && !rx_rdy && timed_out;
  end

  // A completed pair beats a simultaneous clear from the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_byte <= '0;
      to_cnt    <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
    end else begin
      if (load_high) begin
        high_byte <= rx_data;
        to_cnt    <= '0;
      end else if (state == LOW && !timed_out) begin
        to_cnt <= to_cnt + TW'(1);
      end
      if (discard)
        high_byte <= '0;
      if (set_cmd)
        cmd <= {high_byte, rx_data};
      if (set_cmd)
        cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy || load_high)
        cmd_rdy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Self-checking bench for uart_cmd_wrapper with a short baud divisor and timeout.
module tb_uart_cmd_wrapper;
  import uart_pkg::*;

  localparam int B  = 16;
  localparam int TO = 400;

  logic        clk = 1'b0;
  logic        rst_n, RX, TX, cmd_rdy, clr_cmd_rdy, trmt, tx_done;
  logic [15:0] cmd;
  logic [7:0]  resp;

  int checks = 0;
  int passes = 0;

  uart_cmd_wrapper #(.BAUD_DIV(B), .BYTE_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .trmt        (trmt),
    .resp        (resp),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = frame[i];
      repeat (B) @(negedge clk);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk) clr_cmd_rdy = 1'b1;
    @(negedge clk) clr_cmd_rdy = 1'b0;
  endtask

  // Sends b with trmt and checks each bit mid-period plus tx_done timing.
  task automatic check_tx_frame(input logic [7:0] b, input bit inject);
    int exp_bit;
    @(negedge clk);
    trmt = 1'b1;
    resp = b;
    @(negedge clk);
    trmt = 1'b0;
    checks++;
    if (tx_done !== 1'b0) $display("[TB] FAIL tx_done_clear: got %b expected 0", tx_done);
    else passes++;
    for (int k = 1; k <= 10*B; k++) begin
      @(negedge clk);
      if (inject && k == 3*B) begin
        trmt = 1'b1;
        resp = ~b;
      end
      if (inject && k == 3*B + 1) trmt = 1'b0;
      if (k % B == B/2) begin
        if (k / B == 0)      exp_bit = 0;
        else if (k / B == 9) exp_bit = 1;
        else                 exp_bit = (int'(b) >> (k/B - 1)) % 2;
        checks++;
        if (TX !== 1'(exp_bit))
          $display("[TB] FAIL tx_bit%0d of %h: got %b expected %0d", k/B, b, TX, exp_bit);
        else passes++;
      end
      if (k == 10*B - 1) begin
        checks++;
        if (tx_done !== 1'b0) $display("[TB] FAIL tx_done_early: got %b expected 0", tx_done);
        else passes++;
      end
      if (k == 10*B) begin
        checks++;
        if (tx_done !== 1'b1 || TX !== 1'b1)
          $display("[TB] FAIL tx_done_end: got done=%b TX=%b expected 1/1", tx_done, TX);
        else passes++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; RX = 1'b1; trmt = 1'b0; clr_cmd_rdy = 1'b0; resp = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (TX !== 1'b1 || cmd !== 16'h0000 || cmd_rdy !== 1'b0 || tx_done !== 1'b0)
      $display("[TB] FAIL reset_values: got TX=%b cmd=%h rdy=%b done=%b expected 1/0000/0/0",
               TX, cmd, cmd_rdy, tx_done);
    else passes++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cmd_basic();
    send_byte(8'h60);
    send_byte(8'h20);
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h6020)
      $display("[TB] FAIL basic_cmd: got rdy=%b cmd=%h expected 1/6020", cmd_rdy, cmd);
    else passes++;
    pulse_clr();
    checks++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'h6020)
      $display("[TB] FAIL basic_clr: got rdy=%b cmd=%h expected 0/6020", cmd_rdy, cmd);
    else passes++;
  endtask

  task automatic test_tx();
    check_tx_frame(POS_ACK, 1'b1);
  endtask

  task automatic test_timeout();
    send_byte(8'h20);
    repeat (TO + 10) @(negedge clk);
    checks++;
    if (cmd_rdy !== 1'b0) $display("[TB] FAIL timeout_idle: got rdy=%b expected 0", cmd_rdy);
    else passes++;
    send_byte(8'h40);
    checks++;
    if (cmd_rdy !== 1'b0)
      $display("[TB] FAIL timeout_discard: got rdy=%b cmd=%h expected rdy 0", cmd_rdy, cmd);
    else passes++;
    send_byte(8'h00);
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h4000)
      $display("[TB] FAIL timeout_pair: got rdy=%b cmd=%h expected 1/4000", cmd_rdy, cmd);
    else passes++;
  endtask

  task automatic test_clr_collision();
    bit seen;
    send_byte(8'h20);
    checks++;
    if (cmd_rdy !== 1'b0) $display("[TB] FAIL high_byte_clears: got rdy=%b expected 0", cmd_rdy);
    else passes++;
    seen = 1'b0;
    fork
      send_byte(8'h00);
      begin
        clr_cmd_rdy = 1'b1;
        for (int k = 0; k < 12*B && !seen; k++) begin
          @(negedge clk);
          if (cmd_rdy === 1'b1) begin
            seen = 1'b1;
            clr_cmd_rdy = 1'b0;
          end
        end
        clr_cmd_rdy = 1'b0;
      end
    join
    checks++;
    if (seen !== 1'b1) $display("[TB] FAIL collision_set: got rdy never high expected set to win");
    else passes++;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h2000)
      $display("[TB] FAIL collision_hold: got rdy=%b cmd=%h expected 1/2000", cmd_rdy, cmd);
    else passes++;
  endtask

  task automatic test_full_duplex();
    fork
      begin
        send_byte(8'h2F);
        send_byte(8'h01);
      end
      check_tx_frame(MOVE_ACK, 1'b0);
    join
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h2F01)
      $display("[TB] FAIL duplex_cmd: got rdy=%b cmd=%h expected 1/2f01", cmd_rdy, cmd);
    else passes++;
  endtask

  task automatic test_reset_mid_frame();
    pulse_clr();
    @(negedge clk) begin trmt = 1'b1; resp = 8'h00; end
    @(negedge clk) trmt = 1'b0;
    RX = 1'b0;
    repeat (4*B) @(negedge clk);
    rst_n = 1'b0;
    RX = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (TX !== 1'b1 || cmd_rdy !== 1'b0 || cmd !== 16'h0000 || tx_done !== 1'b0)
        $display("[TB] FAIL reset_mid: got TX=%b rdy=%b cmd=%h done=%b expected 1/0/0000/0",
                 TX, cmd_rdy, cmd, tx_done);
      else passes++;
    end
    rst_n = 1'b1;
    repeat (2*B) @(negedge clk);
    send_byte(8'h30);
    checks++;
    if (cmd_rdy !== 1'b0 || TX !== 1'b1)
      $display("[TB] FAIL reset_spurious: got rdy=%b TX=%b expected 0/1", cmd_rdy, TX);
    else passes++;
    send_byte(8'h07);
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h3007)
      $display("[TB] FAIL reset_recover: got rdy=%b cmd=%h expected 1/3007", cmd_rdy, cmd);
    else passes++;
  endtask

  task automatic test_random();
    logic [7:0] hi, lo;
    int exp_cmd;
    for (int n = 0; n < 6; n++) begin
      hi = 8'($urandom_range(0, 255));
      lo = 8'($urandom_range(0, 255));
      exp_cmd = int'(hi) * 256 + int'(lo);
      send_byte(hi);
      send_byte(lo);
      checks++;
      if (cmd_rdy !== 1'b1 || cmd !== 16'(exp_cmd))
        $display("[TB] FAIL random_cmd%0d: got rdy=%b cmd=%h expected 1/%h", n, cmd_rdy, cmd, 16'(exp_cmd));
      else passes++;
      pulse_clr();
      checks++;
      if (cmd_rdy !== 1'b0) $display("[TB] FAIL random_clr%0d: got rdy=%b expected 0", n, cmd_rdy);
      else passes++;
    end
    for (int n = 0; n < 3; n++)
      check_tx_frame(8'($urandom_range(0, 255)), 1'b0);
  endtask

  initial begin
    test_reset();
    test_cmd_basic();
    test_tx();
    test_timeout();
    test_clr_collision();
    test_full_duplex();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
